uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, LSB first, idle-high line.
//
// Parameters:
//   CLKS_PER_BIT  i_Clock cycles per serial bit period (>= 4)
//
// Ports:
//   i_Clock      sole clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Rx_Serial  asynchronous serial input (synchronized internally)
//   o_Rx_DV      one-cycle pulse: o_Rx_Byte holds a freshly received byte
//   o_Rx_Byte    last received byte, held between pulses
//   o_Rx_Active  high from entry to START until entry to CLEANUP
//   o_Rx_Err     one-cycle framing-error pulse (stop bit sampled low)
//
// Build option:
//   UART_RX_FRAMING_CHECK_EN  when defined, a low stop sample pulses o_Rx_Err
//                             instead of o_Rx_DV and leaves o_Rx_Byte alone.
//                             When undefined, o_Rx_Err is tied low and every
//                             completed frame pulses o_Rx_DV.
//
// Handshake: o_Rx_DV is a valid-only strobe with no ready/back-pressure; the
// consumer must capture o_Rx_Byte in the cycle o_Rx_DV is high (the byte also
// stays put afterwards until the next pulse).
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 5000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] C_BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF     = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t        r_State;
    state_t        w_Next_State;
    logic          r_Rx_Meta;
    logic          r_Rx_Sync;
    logic [CW-1:0] r_Clk_Count;
    logic [2:0]    r_Bit_Index;
    logic [7:0]    r_Shift;      // frame assembly, kept off the output port
    logic          r_Stop_Done;  // stop bit sampled; current cycle is the pulse cycle
    logic          r_Break;      // stop sampled low; block restarts until line goes high
    logic          r_Rx_DV;
    logic [7:0]    r_Rx_Byte;
`ifdef UART_RX_FRAMING_CHECK_EN
    logic          r_Rx_Err;
`endif

    // Next-state logic
    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            S_IDLE: begin
                if (!r_Rx_Sync && !r_Break) w_Next_State = S_START;
            end
            S_START: begin
                // Mid-start check: a line that has gone back high is a glitch.
                if (r_Clk_Count == C_HALF) w_Next_State = r_Rx_Sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_Clk_Count == C_BIT_LAST && r_Bit_Index == 3'd7) w_Next_State = S_STOP;
            end
            S_STOP: begin
                if (r_Stop_Done) w_Next_State = S_CLEANUP;
            end
            S_CLEANUP: w_Next_State = S_IDLE;
            default:   w_Next_State = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State     <= S_IDLE;
            r_Rx_Meta   <= 1'b1;
            r_Rx_Sync   <= 1'b1;
            r_Clk_Count <= '0;
            r_Bit_Index <= 3'd0;
            r_Shift     <= 8'h00;
            r_Stop_Done <= 1'b0;
            r_Break     <= 1'b0;
            r_Rx_DV     <= 1'b0;
            r_Rx_Byte   <= 8'h00;
`ifdef UART_RX_FRAMING_CHECK_EN
            r_Rx_Err    <= 1'b0;
`endif
        end else begin
            r_State   <= w_Next_State;
            r_Rx_Meta <= i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;

            case (r_State)
                S_IDLE: begin
                    r_Clk_Count <= '0;
                    r_Bit_Index <= 3'd0;
                    if (r_Rx_Sync) r_Break <= 1'b0;
                end
                S_START: begin
                    if (r_Clk_Count == C_HALF) r_Clk_Count <= '0;
                    else                       r_Clk_Count <= r_Clk_Count + 1'b1;
                end
                S_DATA: begin
                    if (r_Clk_Count == C_BIT_LAST) begin
                        r_Clk_Count          <= '0;
                        r_Shift[r_Bit_Index] <= r_Rx_Sync;
                        r_Bit_Index          <= (r_Bit_Index == 3'd7) ? 3'd0 : r_Bit_Index + 3'd1;
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_Stop_Done) begin
                        // Pulse cycle ends here; outputs drop on entry to CLEANUP.
                        r_Stop_Done <= 1'b0;
                        r_Rx_DV     <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
                        r_Rx_Err    <= 1'b0;
`endif
                    end else if (r_Clk_Count == C_BIT_LAST) begin
                        r_Clk_Count <= '0;
                        r_Stop_Done <= 1'b1;
                        r_Break     <= ~r_Rx_Sync;
`ifdef UART_RX_FRAMING_CHECK_EN
                        if (r_Rx_Sync) begin
                            r_Rx_DV   <= 1'b1;
                            r_Rx_Byte <= r_Shift;
                        end else begin
                            r_Rx_Err  <= 1'b1;
                        end
`else
                        r_Rx_DV   <= 1'b1;
                        r_Rx_Byte <= r_Shift;
`endif
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    r_Clk_Count <= '0;
                    r_Bit_Index <= 3'd0;
                end
                default: begin
                    r_Clk_Count <= '0;
                    r_Bit_Index <= 3'd0;
                    r_Stop_Done <= 1'b0;
                    r_Rx_DV     <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
                    r_Rx_Err    <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign o_Rx_DV     = r_Rx_DV;
    assign o_Rx_Byte   = r_Rx_Byte;
    assign o_Rx_Active = (r_State == S_START) || (r_State == S_DATA) || (r_State == S_STOP);
`ifdef UART_RX_FRAMING_CHECK_EN
    assign o_Rx_Err    = r_Rx_Err;
`else
    assign o_Rx_Err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx.
// Two receivers: u_dut at 16 clocks/bit for the directed frames, u_dut87 at
// 87 clocks/bit fed by a bench-side transmitter task for the loopback sweep.
// Expected bytes are queued when a frame is driven and popped by a monitor
// when the receiver pulses o_Rx_DV.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  localparam int CPB    = 16;
  localparam int CPB_LB = 87;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx16, rx87;
  logic       dv16, act16, err16;
  logic [7:0] byte16;
  logic       dv87, act87, err87;
  logic [7:0] byte87;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx16),
    .o_Rx_DV(dv16), .o_Rx_Byte(byte16), .o_Rx_Active(act16), .o_Rx_Err(err16)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_LB)) u_dut87 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx87),
    .o_Rx_DV(dv87), .o_Rx_Byte(byte87), .o_Rx_Active(act87), .o_Rx_Err(err87)
  );

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q87[$];
  int         dv_times[$];
  int         dv_cnt = 0, err_cnt = 0, dv87_cnt = 0, err87_cnt = 0;
  logic       prev_dv = 1'b0;
  logic       act_ok;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // monitor: pops the expected queue on every data-valid pulse
  always @(negedge clk) begin
    if (dv16) begin
      dv_cnt++;
      dv_times.push_back(cyc);
      check("dv_width", {31'b0, prev_dv}, 32'd0);
      check("dv_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) check("rx_byte", {24'b0, byte16}, {24'b0, exp_q.pop_front()});
    end
    if (err16) err_cnt++;
    prev_dv = dv16;
    if (dv87) begin
      dv87_cnt++;
      check("lb_expected", (exp_q87.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q87.size() > 0) check("lb_byte", {24'b0, byte87}, {24'b0, exp_q87.pop_front()});
    end
    if (err87) err87_cnt++;
  end

  // driver: one full 8N1 frame on the chosen line, starting at a negedge
  task automatic send_frame(input bit which, input logic [7:0] b, input logic stop);
    int cpb;
    logic [9:0] f;
    cpb = which ? CPB_LB : CPB;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (which) rx87 = f[k];
      else       rx16 = f[k];
      repeat (cpb / 2) @(negedge clk);
      if (!which && k > 0) act_ok = act_ok & act16;
      repeat (cpb - cpb / 2) @(negedge clk);
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] last_byte;
    logic [7:0] b;
    logic [9:0] f;
    int rise, fall, n0, dv_before, err_before;

    rst = 1'b1; rx16 = 1'b1; rx87 = 1'b1; act_ok = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dv",     {31'b0, dv16},   32'd0);
    check("reset_err",    {31'b0, err16},  32'd0);
    check("reset_active", {31'b0, act16},  32'd0);
    check("reset_byte",   {24'b0, byte16}, 32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single frame 0xA5
    exp_q.push_back(8'hA5);
    act_ok = 1'b1;
    send_frame(0, 8'hA5, 1'b1);
    rx16 = 1'b1;
    repeat (8) @(negedge clk);
    check("a5_active_during", {31'b0, act_ok}, 32'd1);
    check("a5_dv_count", dv_cnt, 1);
    check("a5_err_count", err_cnt, 0);
    check("a5_byte_held", {24'b0, byte16}, 32'hA5);
    check("a5_active_after", {31'b0, act16}, 32'd0);
    last_byte = 8'hA5;

    // 4-clock low glitch on idle line
    rise = -1; fall = -1;
    rx16 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) rx16 = 1'b1;
      if (act16 && rise < 0) rise = i;
      if (!act16 && rise >= 0 && fall < 0) fall = i;
    end
    check("glitch_active_rose", (rise >= 0) ? 32'd1 : 32'd0, 32'd1);
    check_range("glitch_active_len", fall - rise, 1, 9);
    check("glitch_dv_count", dv_cnt, 1);
    check("glitch_err_count", err_cnt, 0);
    check("glitch_byte", {24'b0, byte16}, 32'hA5);

    // back-to-back 0x00, 0xFF
    n0 = dv_times.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(0, 8'h00, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    rx16 = 1'b1;
    repeat (8) @(negedge clk);
    check("b2b_dv_count", dv_cnt, 3);
    if (dv_times.size() >= n0 + 2) check_range("b2b_spacing", dv_times[n0+1] - dv_times[n0], 158, 162);
    last_byte = 8'hFF;

    // random back-to-back burst
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(0, b, 1'b1);
      last_byte = b;
    end
    rx16 = 1'b1;
    repeat (8) @(negedge clk);
    check("burst_dv_count", dv_cnt, 9);
    check("burst_byte", {24'b0, byte16}, {24'b0, last_byte});

    // 0x3C with a low stop bit (line then returns high)
`ifdef UART_RX_FRAMING_CHECK_EN
    send_frame(0, 8'h3C, 1'b0);
    rx16 = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_err_count", err_cnt, 1);
    check("ferr_dv_count", dv_cnt, 9);
    check("ferr_byte_held", {24'b0, byte16}, {24'b0, last_byte});
`else
    exp_q.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b0);
    rx16 = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_err_count", err_cnt, 0);
    check("ferr_dv_count", dv_cnt, 10);
    check("ferr_byte", {24'b0, byte16}, 32'h3C);
`endif
    check("ferr_idle_after", {31'b0, act16}, 32'd0);

    // reset during data bit 4 of 0x5A
    dv_before = dv_cnt;
    err_before = err_cnt;
    f = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx16 = f[k];
      repeat (CPB) @(negedge clk);
    end
    rx16 = f[5];
    repeat (CPB / 2) @(negedge clk);
    check("midframe_active", {31'b0, act16}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_dv",     {31'b0, dv16},   32'd0);
    check("rst_mid_err",    {31'b0, err16},  32'd0);
    check("rst_mid_active", {31'b0, act16},  32'd0);
    check("rst_mid_byte",   {24'b0, byte16}, 32'h00);
    rx16 = 1'b1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_no_dv", dv_cnt, dv_before);
    check("rst_mid_no_err", err_cnt, err_before);
    exp_q.push_back(8'h81);
    send_frame(0, 8'h81, 1'b1);
    rx16 = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_dv_count", dv_cnt, dv_before + 1);
    check("post_rst_byte", {24'b0, byte16}, 32'h81);

    // loopback sweep at 87 clocks/bit: corner values plus random bytes
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: b = 8'h00;
        1: b = 8'hFF;
        2: b = 8'h55;
        3: b = 8'hAA;
        4: b = 8'h01;
        5: b = 8'h80;
        default: b = 8'($urandom_range(0, 255));
      endcase
      exp_q87.push_back(b);
      send_frame(1, b, 1'b1);
    end
    rx87 = 1'b1;
    repeat (20) @(negedge clk);
    check("lb_dv_count", dv87_cnt, 24);
    check("lb_err_count", err87_cnt, 0);
    check("lb_queue_empty", exp_q87.size(), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
